// File: rtl/machine_seq_pkg.sv
// rtl/machine_seq_pkg.sv - shared state encoding and defaults for the machine sequencer
package machine_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_HALT      = 2'd2,
      ST_STEP_WAIT = 2'd3
   } seq_state_e;

   localparam int DEF_NUM_PHASES = 8;

endpackage

// File: rtl/machine_phase_cnt.sv
// rtl/machine_phase_cnt.sv - modulo-NUM_PHASES phase counter with clear/increment and last flag
module machine_phase_cnt
   import machine_seq_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   localparam int PH_W = $clog2(NUM_PHASES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            inc,
   output logic [PH_W-1:0] count,
   output logic            last
);

   localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

   logic [PH_W-1:0] count_q;
   logic [PH_W-1:0] count_d;

   assign last  = (count_q == LAST_PH);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = last ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/machine_seq_ctrl.sv
// rtl/machine_seq_ctrl.sv - instruction phase sequencer with halt/resume and single-step
// Optional retired-instruction counter: MACHINE_SEQ_CTRL_INSTR_CNT_EN
module machine_seq_ctrl
   import machine_seq_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int CNT_W      = 16,
   localparam int PH_W      = $clog2(NUM_PHASES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch,
   input  logic             halt,
   input  logic             resume,
   input  logic             step_mode,
   input  logic             step_req,
   output logic             ena,
   output logic [PH_W-1:0]  phase,
   output logic             phase_last,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] instr_cnt
);

   seq_state_e      state_q;
   seq_state_e      state_d;
   logic            halt_pend_q;
   logic            halt_pend_d;
   logic [PH_W-1:0] ph_cnt;
   logic            ph_last;

   assign ena        = (state_q == ST_RUN);
   assign phase      = ena ? ph_cnt : '0;
   assign phase_last = ena & ph_last;
   assign state      = state_q;

   // Counter is held at zero outside RUN, so every entry into RUN starts at phase 0.
   machine_phase_cnt #(
      .NUM_PHASES (NUM_PHASES)
   ) u_phase_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (!ena),
      .inc   (ena),
      .count (ph_cnt),
      .last  (ph_last)
   );

   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch) begin
               state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
            end
         end
         ST_RUN: begin
            halt_pend_d = halt_pend_q | halt;
            if (ph_last) begin
               if (halt_pend_q || halt) begin
                  state_d     = ST_HALT;
                  halt_pend_d = 1'b0;
               end else if (step_mode) begin
                  state_d = ST_STEP_WAIT;
               end
            end
         end
         ST_HALT: begin
            halt_pend_d = 1'b0;
            if (resume) begin
               state_d = step_mode ? ST_STEP_WAIT : ST_RUN;
            end
         end
         ST_STEP_WAIT: begin
            if (step_req) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            halt_pend_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         halt_pend_q <= halt_pend_d;
      end
   end

`ifdef MACHINE_SEQ_CTRL_INSTR_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (phase_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_cnt = cnt_q;
`else
   assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_machine_seq_ctrl.sv
// tb/tb_machine_seq_ctrl.sv - directed self-checking bench for machine_seq_ctrl
module tb_machine_seq_ctrl;

   localparam int NP = 8;
   localparam int CW = 4;
   localparam int PW = $clog2(NP);
`ifdef MACHINE_SEQ_CTRL_INSTR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fetch = 1'b0;
   logic          halt = 1'b0;
   logic          resume = 1'b0;
   logic          step_mode = 1'b0;
   logic          step_req = 1'b0;
   logic          ena;
   logic [PW-1:0] phase;
   logic          phase_last;
   logic [1:0]    state;
   logic [CW-1:0] instr_cnt;

   int checks = 0;
   int failures = 0;

   machine_seq_ctrl #(
      .NUM_PHASES (NP),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fetch      (fetch),
      .halt       (halt),
      .resume     (resume),
      .step_mode  (step_mode),
      .step_req   (step_req),
      .ena        (ena),
      .phase      (phase),
      .phase_last (phase_last),
      .state      (state),
      .instr_cnt  (instr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] cnt_exp(input int n);
      return CNT_EN ? CW'(n) : '0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      fetch = 0; halt = 0; resume = 0; step_mode = 0; step_req = 0;
      rst = 0;
      tick();
      rst = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++;
      if (ena !== 1'b0 || phase !== '0) begin failures++; $display("FAIL reset_ena_phase got=%b/%0d exp=0/0", ena, phase); end
      checks++;
      if (instr_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", instr_cnt); end
      halt = 1; resume = 1; step_req = 1;
      repeat (3) tick();
      halt = 0; resume = 0; step_req = 0;
      checks++;
      if (state !== 2'd0 || ena !== 1'b0) begin failures++; $display("FAIL idle_ignores got=%0d/%b exp=0/0", state, ena); end
   endtask

   task automatic test_start();
      int bad = 0;
      do_reset();
      repeat (4) tick();
      fetch = 1;
      tick();
      fetch = 0;
      for (int i = 0; i < 2 * NP; i++) begin
         if (ena !== 1'b1 || phase !== PW'(i % NP) || phase_last !== (i % NP == NP - 1)) begin
            bad++;
            $display("FAIL start_seq cyc=%0d got ena=%b ph=%0d last=%b exp ena=1 ph=%0d", i, ena, phase, phase_last, i % NP);
         end
         if (i == 3) fetch = 1;
         tick();
         fetch = 0;
      end
      checks++;
      if (bad != 0) failures++;
      checks++;
      if (instr_cnt !== cnt_exp(2)) begin failures++; $display("FAIL start_cnt got=%0d exp=%0d", instr_cnt, cnt_exp(2)); end
      checks++;
      if (ena !== 1'b1 || phase !== '0 || state !== 2'd1) begin failures++; $display("FAIL start_no_bubble got=%b/%0d/%0d exp=1/0/1", ena, phase, state); end
   endtask

   task automatic test_latched_halt();
      int bad = 0;
      do_reset();
      fetch = 1;
      tick();
      fetch = 0;
      repeat (3) tick();
      halt = 1;
      tick();
      halt = 0;
      for (int k = 4; k < NP; k++) begin
         if (ena !== 1'b1 || phase !== PW'(k)) begin
            bad++;
            $display("FAIL halt_finish got ena=%b ph=%0d exp ena=1 ph=%0d", ena, phase, k);
         end
         tick();
      end
      checks++;
      if (bad != 0) failures++;
      checks++;
      if (state !== 2'd2 || ena !== 1'b0 || phase !== '0) begin failures++; $display("FAIL halt_enter got=%0d/%b/%0d exp=2/0/0", state, ena, phase); end
      checks++;
      if (instr_cnt !== cnt_exp(1)) begin failures++; $display("FAIL halt_cnt got=%0d exp=%0d", instr_cnt, cnt_exp(1)); end
      fetch = 1; halt = 1; step_req = 1;
      repeat (3) tick();
      fetch = 0; halt = 0; step_req = 0;
      checks++;
      if (state !== 2'd2 || ena !== 1'b0) begin failures++; $display("FAIL halt_ignores got=%0d/%b exp=2/0", state, ena); end
      resume = 1;
      tick();
      resume = 0;
      checks++;
      if (state !== 2'd1 || ena !== 1'b1 || phase !== '0) begin failures++; $display("FAIL resume got=%0d/%b/%0d exp=1/1/0", state, ena, phase); end
      repeat (NP) tick();
      checks++;
      if (state !== 2'd1 || phase !== '0) begin failures++; $display("FAIL halt_pend_cleared got=%0d/%0d exp=1/0", state, phase); end
      repeat (NP - 1) tick();
      halt = 1;
      tick();
      halt = 0;
      checks++;
      if (state !== 2'd2 || instr_cnt !== cnt_exp(3)) begin failures++; $display("FAIL halt_at_last got=%0d/%0d exp=2/%0d", state, instr_cnt, cnt_exp(3)); end
   endtask

   task automatic test_single_step();
      int bursts_bad = 0;
      int n;
      do_reset();
      step_mode = 1;
      fetch = 1;
      tick();
      fetch = 0;
      checks++;
      if (state !== 2'd3 || ena !== 1'b0 || phase !== '0) begin failures++; $display("FAIL step_enter got=%0d/%b/%0d exp=3/0/0", state, ena, phase); end
      for (int b = 0; b < 3; b++) begin
         step_req = 1;
         tick();
         step_req = 0;
         n = 0;
         for (int c = 0; c < 20; c++) begin
            if (ena === 1'b1) n++;
            tick();
         end
         if (n != NP || state !== 2'd3) begin
            bursts_bad++;
            $display("FAIL step_burst b=%0d got len=%0d st=%0d exp len=%0d st=3", b, n, state, NP);
         end
      end
      checks++;
      if (bursts_bad != 0) failures++;
      checks++;
      if (instr_cnt !== cnt_exp(3)) begin failures++; $display("FAIL step_cnt got=%0d exp=%0d", instr_cnt, cnt_exp(3)); end
      resume = 1; halt = 1;
      tick();
      resume = 0; halt = 0;
      checks++;
      if (state !== 2'd3) begin failures++; $display("FAIL step_ignores got=%0d exp=3", state); end
      step_req = 1;
      tick();
      step_req = 0;
      repeat (2) tick();
      step_mode = 0;
      repeat (NP - 2) tick();
      checks++;
      if (state !== 2'd1 || ena !== 1'b1 || phase !== '0) begin failures++; $display("FAIL step_drop_freerun got=%0d/%b/%0d exp=1/1/0", state, ena, phase); end
   endtask

   task automatic test_halt_and_step();
      do_reset();
      step_mode = 1;
      fetch = 1;
      tick();
      fetch = 0;
      step_req = 1;
      tick();
      step_req = 0;
      repeat (NP - 1) tick();
      checks++;
      if (phase_last !== 1'b1 || phase !== PW'(NP - 1)) begin failures++; $display("FAIL hs_last got=%b/%0d exp=1/%0d", phase_last, phase, NP - 1); end
      halt = 1;
      tick();
      halt = 0;
      checks++;
      if (state !== 2'd2 || ena !== 1'b0) begin failures++; $display("FAIL hs_priority got=%0d/%b exp=2/0", state, ena); end
      resume = 1;
      tick();
      resume = 0;
      checks++;
      if (state !== 2'd3 || ena !== 1'b0) begin failures++; $display("FAIL hs_resume_step got=%0d/%b exp=3/0", state, ena); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch = 1;
      tick();
      fetch = 0;
      repeat (NP + 4) tick();
      checks++;
      if (phase !== PW'(4) || instr_cnt !== cnt_exp(1)) begin failures++; $display("FAIL mid_pre got=%0d/%0d exp=4/%0d", phase, instr_cnt, cnt_exp(1)); end
      rst = 0;
      tick();
      rst = 1;
      checks++;
      if (state !== 2'd0 || ena !== 1'b0 || phase !== '0 || instr_cnt !== '0) begin
         failures++;
         $display("FAIL mid_reset got=%0d/%b/%0d/%0d exp=0/0/0/0", state, ena, phase, instr_cnt);
      end
      fetch = 1;
      tick();
      fetch = 0;
      checks++;
      if (ena !== 1'b1 || phase !== '0) begin failures++; $display("FAIL mid_restart got=%b/%0d exp=1/0", ena, phase); end
      tick();
      checks++;
      if (phase !== PW'(1)) begin failures++; $display("FAIL mid_restart_inc got=%0d exp=1", phase); end
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      fetch = 1;
      tick();
      fetch = 0;
      repeat (15 * NP) tick();
      checks++;
      if (instr_cnt !== cnt_exp(15)) begin failures++; $display("FAIL wrap_15 got=%0d exp=%0d", instr_cnt, cnt_exp(15)); end
      repeat (2 * NP) tick();
      checks++;
      if (instr_cnt !== cnt_exp(17)) begin failures++; $display("FAIL wrap_17 got=%0d exp=%0d", instr_cnt, cnt_exp(17)); end
      checks++;
      if (ena !== 1'b1 || phase !== '0) begin failures++; $display("FAIL wrap_run got=%b/%0d exp=1/0", ena, phase); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_latched_halt();
      test_single_step();
      test_halt_and_step();
      test_reset_mid();
      test_cnt_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
